// File: rtl/id_ex_ctrl.sv
// id_ex_ctrl: IR latch, ALU-control decode and ID->EX->WB staging for the
// 3-stage MIPS32 datapath, with stall/flush and illegal-instruction count.
module id_ex_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] ibus,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] Asel,
    output logic [31:0] Bsel,
    output logic        I,
    output logic [2:0]  S,
    output logic        Cin,
    output logic        ex_valid,
    output logic        ex_illegal,
    output logic [31:0] Dsel,
    output logic        wb_valid,
    output logic [7:0]  illegal_cnt
);

    logic [31:0] ir;
    logic [4:0]  ex_dest;

    logic        d_i;
    logic [2:0]  d_s;
    logic        d_cin;
    logic        d_valid;
    logic        d_illegal;
    logic [4:0]  d_dest;

    // Register selects come straight from IR, legal or not.
    assign Asel = 32'h1 << ir[25:21];
    assign Bsel = 32'h1 << ir[20:16];

    // Decode IR into ALU controls; unmatched nonzero words are illegal.
    always_comb begin
        d_i       = 1'b0;
        d_s       = 3'b111;
        d_cin     = 1'b0;
        d_valid   = 1'b0;
        d_illegal = 1'b0;
        d_dest    = ir[20:16];
        if (ir != 32'h0) begin
            if (ir[31:26] == 6'b000000) begin
                d_dest  = ir[15:11];
                d_valid = 1'b1;
                case (ir[5:0])
                    6'b000011: d_s = 3'b010;
                    6'b000010: begin d_s = 3'b011; d_cin = 1'b1; end
                    6'b000001: d_s = 3'b000;
                    6'b000111: d_s = 3'b110;
                    6'b000100: d_s = 3'b100;
                    default: begin d_valid = 1'b0; d_illegal = 1'b1; end
                endcase
            end else begin
                d_i     = 1'b1;
                d_valid = 1'b1;
                case (ir[31:26])
                    6'b000011: d_s = 3'b010;
                    6'b000010: begin d_s = 3'b011; d_cin = 1'b1; end
                    6'b000001: d_s = 3'b000;
                    6'b001111: d_s = 3'b110;
                    6'b001100: d_s = 3'b100;
                    default: begin d_i = 1'b0; d_valid = 1'b0; d_illegal = 1'b1; end
                endcase
            end
            if (d_illegal) d_s = 3'b111;
        end
    end

    // IR: flush beats stall, otherwise follow fetch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   ir <= 32'h0;
        else if (flush) ir <= 32'h0;
        else if (!stall) ir <= ibus;
    end

    // EX stage: freezes on stall, ignores flush.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            I          <= 1'b0;
            S          <= 3'b111;
            Cin        <= 1'b0;
            ex_valid   <= 1'b0;
            ex_illegal <= 1'b0;
            ex_dest    <= 5'd0;
        end else if (!stall) begin
            I          <= d_i;
            S          <= d_s;
            Cin        <= d_cin;
            ex_valid   <= d_valid;
            ex_illegal <= d_illegal;
            ex_dest    <= d_dest;
        end
    end

    // WB stage: a stall injects a bubble so a held EX op writes back once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_valid <= 1'b0;
            Dsel     <= 32'h0;
        end else if (stall) begin
            wb_valid <= 1'b0;
            Dsel     <= 32'h0;
        end else begin
            wb_valid <= ex_valid;
            Dsel     <= ex_valid ? (32'h1 << ex_dest) : 32'h0;
        end
    end

    // Saturating count of illegal words accepted into EX.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            illegal_cnt <= 8'd0;
        else if (!stall && d_illegal && illegal_cnt != 8'hFF)
            illegal_cnt <= illegal_cnt + 8'd1;
    end

endmodule

// File: tb/tb_id_ex_ctrl.sv
// Bench for id_ex_ctrl: directed literal checks plus randomized traffic
// compared every cycle against a behavioural pipeline model.
module tb_id_ex_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [31:0] ibus = 32'h0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] Asel, Bsel, Dsel;
    logic        I, Cin, ex_valid, ex_illegal, wb_valid;
    logic [2:0]  S;
    logic [7:0]  illegal_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    id_ex_ctrl dut (
        .clk(clk), .reset_n(reset_n), .ibus(ibus), .stall(stall), .flush(flush),
        .Asel(Asel), .Bsel(Bsel), .I(I), .S(S), .Cin(Cin),
        .ex_valid(ex_valid), .ex_illegal(ex_illegal),
        .Dsel(Dsel), .wb_valid(wb_valid), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       i;
        bit [2:0] s;
        bit       cin;
        bit       v;
        bit       ill;
        int       dest;
    } dec_t;

    bit [5:0] imm_op [5] = '{6'h03, 6'h02, 6'h01, 6'h0F, 6'h0C};
    bit [5:0] r_fn   [5] = '{6'h03, 6'h02, 6'h01, 6'h07, 6'h04};
    bit [2:0] s_tab  [5] = '{3'd2, 3'd3, 3'd0, 3'd6, 3'd4};

    // Table lookup of the opcode/funct map.
    function automatic dec_t decode(input bit [31:0] w);
        dec_t d;
        d.i = 0; d.s = 3'd7; d.cin = 0; d.v = 0; d.ill = (w != 0); d.dest = 0;
        for (int k = 0; k < 5; k++) begin
            if (w[31:26] == 0 && w[5:0] == r_fn[k] && w != 0) begin
                d.s = s_tab[k]; d.cin = (k == 1); d.v = 1; d.ill = 0;
                d.dest = int'(w[15:11]);
            end
            if (w[31:26] == imm_op[k]) begin
                d.i = 1; d.s = s_tab[k]; d.cin = (k == 1); d.v = 1; d.ill = 0;
                d.dest = int'(w[20:16]);
            end
        end
        return d;
    endfunction

    // Model state.
    bit [31:0] m_ir;
    dec_t      m_ex;
    bit        m_wbv;
    bit [31:0] m_dsel;
    int        m_cnt;

    function automatic dec_t reset_ex();
        dec_t d;
        d.i = 0; d.s = 3'd7; d.cin = 0; d.v = 0; d.ill = 0; d.dest = 0;
        return d;
    endfunction

    // Model advances on the same edges as the DUT (later stages use old values).
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_ir = 0; m_ex = reset_ex(); m_wbv = 0; m_dsel = 0; m_cnt = 0;
        end else begin
            if (!stall && decode(m_ir).ill) m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
            m_wbv  = stall ? 1'b0 : m_ex.v;
            m_dsel = (!stall && m_ex.v) ? (32'h1 << m_ex.dest) : 32'h0;
            if (!stall) m_ex = decode(m_ir);
            if (flush) m_ir = 0;
            else if (!stall) m_ir = ibus;
        end
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", n, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the edge.
    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            chk("m_asel", Asel, 32'h1 << m_ir[25:21]);
            chk("m_bsel", Bsel, 32'h1 << m_ir[20:16]);
            chk("m_i", {31'b0, I}, {31'b0, m_ex.i});
            chk("m_s", {29'b0, S}, {29'b0, m_ex.s});
            chk("m_cin", {31'b0, Cin}, {31'b0, m_ex.cin});
            chk("m_exv", {31'b0, ex_valid}, {31'b0, m_ex.v});
            chk("m_exill", {31'b0, ex_illegal}, {31'b0, m_ex.ill});
            chk("m_wbv", {31'b0, wb_valid}, {31'b0, m_wbv});
            chk("m_dsel", Dsel, m_dsel);
            chk("m_cnt", {24'b0, illegal_cnt}, m_cnt);
        end
    end

    task automatic step(input logic [31:0] w, input logic st, input logic fl);
        @(negedge clk);
        ibus = w; stall = st; flush = fl;
        @(posedge clk);
        #3;
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] r;
        int k;
        r = $urandom;
        k = $urandom_range(0, 9);
        if (k == 0) return 32'h0;
        if (k == 1) return r;
        if (k <= 6) return {imm_op[$urandom_range(0, 4)], r[25:0]};
        return {6'b0, r[25:6], r_fn[$urandom_range(0, 4)]};
    endfunction

    localparam logic [31:0] ADD_R = 32'h00221803;
    localparam logic [31:0] SUB_I = 32'h08850010;
    localparam logic [31:0] BAD   = 32'hFC000000;

    initial begin
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        chk_en = 1'b1;
        chk("rst_s", {29'b0, S}, 32'd7);
        chk("rst_asel", Asel, 32'h1);
        chk("rst_cnt", {24'b0, illegal_cnt}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Latency through the three stages.
        step(ADD_R, 0, 0);
        chk("add_asel", Asel, 32'h2);
        chk("add_bsel", Bsel, 32'h4);
        step(SUB_I, 0, 0);
        chk("add_s", {29'b0, S}, 32'd2);
        chk("add_exv", {31'b0, ex_valid}, 32'd1);
        chk("add_i", {31'b0, I}, 32'd0);
        step(BAD, 0, 0);
        chk("add_dsel", Dsel, 32'h8);
        chk("add_wbv", {31'b0, wb_valid}, 32'd1);
        chk("sub_s", {29'b0, S}, 32'd3);
        chk("sub_i", {31'b0, I}, 32'd1);
        chk("sub_cin", {31'b0, Cin}, 32'd1);
        step(32'h0, 0, 0);
        chk("sub_dsel", Dsel, 32'h20);
        chk("bad_ill", {31'b0, ex_illegal}, 32'd1);
        chk("bad_exv", {31'b0, ex_valid}, 32'd0);
        chk("bad_s", {29'b0, S}, 32'd7);
        chk("bad_cnt", {24'b0, illegal_cnt}, 32'd1);
        step(32'h0, 0, 0);
        chk("bad_wbv", {31'b0, wb_valid}, 32'd0);

        // Stall with an add in EX: held, bubbles, then one writeback.
        step(ADD_R, 0, 0);
        step(32'h0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(SUB_I, 1, 0);
            chk("stl_s", {29'b0, S}, 32'd2);
            chk("stl_wbv", {31'b0, wb_valid}, 32'd0);
        end
        step(32'h0, 0, 0);
        chk("stl_wb_once", Dsel, 32'h8);
        step(32'h0, 0, 0);
        chk("stl_wb_gone", {31'b0, wb_valid}, 32'd0);

        // Flush together with stall.
        step(ADD_R, 0, 0);
        step(SUB_I, 0, 0);
        step(ADD_R, 1, 1);
        chk("fl_asel", Asel, 32'h1);
        chk("fl_ex_held", {29'b0, S}, 32'd2);
        step(32'h0, 0, 0);
        chk("fl_nop_s", {29'b0, S}, 32'd7);
        chk("fl_nop_v", {31'b0, ex_valid}, 32'd0);

        // Randomized traffic.
        for (int k = 0; k < 400; k++)
            step(rand_word(), ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));

        // Asynchronous reset mid-stream with all stages full.
        step(ADD_R, 0, 0);
        step(SUB_I, 0, 0);
        step(ADD_R, 0, 0);
        reset_n = 1'b0;
        #1;
        chk("ar_asel", Asel, 32'h1);
        chk("ar_bsel", Bsel, 32'h1);
        chk("ar_s", {29'b0, S}, 32'd7);
        chk("ar_i", {31'b0, I}, 32'd0);
        chk("ar_exv", {31'b0, ex_valid}, 32'd0);
        chk("ar_dsel", Dsel, 32'h0);
        chk("ar_wbv", {31'b0, wb_valid}, 32'd0);
        chk("ar_cnt", {24'b0, illegal_cnt}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1; ibus = ADD_R; stall = 1'b0; flush = 1'b0;
        @(posedge clk);
        #3;
        step(32'h0, 0, 0);
        chk("ar_add_s", {29'b0, S}, 32'd2);
        chk("ar_add_v", {31'b0, ex_valid}, 32'd1);

        // Saturation.
        for (int k = 0; k < 300; k++) step(BAD, 0, 0);
        chk("sat_cnt", {24'b0, illegal_cnt}, 32'd255);
        step(BAD, 0, 0);
        chk("sat_hold", {24'b0, illegal_cnt}, 32'd255);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/id_ex_ctrl.md
# id_ex_ctrl

Pipeline control sequencer for the 3-stage (IF/ID, EX, WB) MIPS32 datapath. It latches the fetched instruction word, decodes the register selects and the ALU controls (I, S, Cin) using the team's fixed opcode/funct map, and stages them into EX. It then delays the destination select to WB so the register file writes back in the correct cycle. It also supports stall and flush, and flags and counts illegal instructions.

## Interface
- No parameters (register file is fixed at 32 registers).
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- ibus  in  32  instruction word from fetch, sampled every unstalled edge
- stall  in  1  hold IR and EX stage registers
- flush  in  1  replace the IR contents with NOP
- Asel  out  32  one-hot rs select (ID stage, combinational from IR)
- Bsel  out  32  one-hot rt select (ID stage, combinational from IR)
- I  out  1  EX: immediate operand select
- S  out  3  EX: ALU function select
- Cin  out  1  EX: ALU carry-in
- ex_valid  out  1  EX holds a legal, non-NOP instruction
- ex_illegal  out  1  EX holds an illegal instruction
- Dsel  out  32  WB: one-hot destination select, all-zero when wb_valid=0
- wb_valid  out  1  WB write enable
- illegal_cnt  out  8  saturating illegal-instruction count

## Operation
- Decode map, immediate forms (opcode = ibus[31:26]); all set I=1:
  - 000011: S=010, Cin=0 (add)
  - 000010: S=011, Cin=1 (sub)
  - 000001: S=000, Cin=0 (xor)
  - 001111: S=110, Cin=0 (or)
  - 001100: S=100, Cin=0 (and)
- Decode map, R-type forms (opcode 000000), keyed on funct [5:0]; all set I=0:
  - 000011: S=010, Cin=0
  - 000010: S=011, Cin=1
  - 000001: S=000, Cin=0
  - 000111: S=110, Cin=0
  - 000100: S=100, Cin=0
- Destination: rd [15:11] for R-type; rt [20:16] for immediate forms.
- Asel = 1<<IR[25:21] and Bsel = 1<<IR[20:16] always, including for NOP and illegal words.
- NOP: IR == 32'h0.
  - Decodes to I=0, S=111, Cin=0, ex_valid=0, ex_illegal=0.
- Illegal: any nonzero word outside the map.
  - Decodes to I=0, S=111, Cin=0, ex_valid=0, ex_illegal=1.
  - Never produces a writeback.
- IR update per edge, in priority order:
  - flush=1: IR<=0. Flush wins over stall for IR.
  - else stall=1: IR holds.
  - else: IR<=ibus.
- EX registers (I, S, Cin, ex_valid, ex_illegal, dest): hold when stall=1; otherwise load the IR decode. Flush does not affect EX.
- WB registers (Dsel, wb_valid):
  - stall=1: load a bubble (wb_valid=0, Dsel=0), so a held instruction never writes back twice.
  - otherwise: wb_valid<=ex_valid, Dsel<=ex_valid ? 1<<dest : 0.
- illegal_cnt: increments on an edge where stall=0 and the IR decode is illegal; saturates at 255 and never wraps.

## Timing
- Reset (asynchronous, any cycle, including mid-stall):
  - IR=0, I=0, S=111, Cin=0, ex_valid=0, ex_illegal=0, Dsel=0, wb_valid=0, illegal_cnt=0.
  - Asel=Bsel=32'h1 (decoded from IR=0).
- Latency, with ibus sampled at edge N:
  - Asel/Bsel valid after edge N.
  - I/S/Cin/ex_valid valid after edge N+1.
  - Dsel/wb_valid valid after edge N+2.
- Throughput: one instruction per cycle when stall=0.
- A stall of k cycles freezes IR and EX for k cycles and inserts k WB bubbles. The next unstalled edge resumes with no loss.
- Flush without stall: a NOP enters IR; EX receives that NOP one edge later.
- No combinational path from ibus, stall or flush to any output other than via registers. Asel/Bsel depend on IR only.

## Test plan
- Reset then ibus=0x00221803 (R add rd=3 rs=1 rt=2):
  - After 1 edge: Asel=0x2, Bsel=0x4.
  - After 2 edges: I=0, S=010, Cin=0, ex_valid=1.
  - After 3 edges: Dsel=0x8, wb_valid=1.
- ibus=0x08850010 (sub imm, rs=4 rt=5):
  - EX: I=1, S=011, Cin=1.
  - WB: Dsel=0x20, wb_valid=1.
- ibus=0xFC000000:
  - EX: ex_illegal=1, ex_valid=0, S=111.
  - WB: wb_valid=0.
  - illegal_cnt goes 0->1.
  - 300 consecutive illegal words: illegal_cnt stays at 255.
- Stall for 3 cycles with an add in EX:
  - I/S/Cin held for all 3 cycles.
  - wb_valid=0 for 3 cycles, then the add writes back exactly once.
- flush=1 and stall=1 together with an instruction in IR:
  - IR becomes 0 (Asel=0x1); EX unchanged.
  - After stall release, EX shows a NOP.
- reset_n low mid-stream with valid instructions in every stage:
  - All outputs take their reset values immediately, without waiting for a clock edge.
  - After release, the first ibus appears in EX 2 edges later.
